poly_euclid_align: RTL and testbench
====================================

Name: poly_euclid_align

Overview:
- Consumes two polynomials over GF(2^16) with degrees already produced by the upstream degree-finder.
- Orders the two polynomials by degree and multiplies the lower-degree one by x^delta (delta = degree difference), so both leading coefficients sit in the same slot.
- Outputs both leading coefficients, ready for the Euclidean/Patterson division step's GF multiply-subtract.
- Shifts one coefficient per cycle to reuse the degree-finder's shift datapath style.

Parameters:
- M, 144, polynomial register width in bits.
- CW, 16, coefficient width in bits (GF(2^16)).
- NC, 9, number of coefficients (M/CW); degrees 0..8.
- DW, 4, degree/delta width.

Ports:
- clk  in  1  clock
- rst_b  in  1  reset; synchronous, active-high
- start  in  1  request; sampled only in IDLE
- poly_a  in  [0:M-1]  polynomial A; coefficient i at bits [CW*i : CW*i+CW-1]
- deg_a  in  DW  degree of A (0 for zero polynomial)
- poly_b  in  [0:M-1]  polynomial B, same layout
- deg_b  in  DW  degree of B
- poly_hi  out  [0:M-1]  higher-degree operand, unshifted
- poly_lo_sh  out  [0:M-1]  lower-degree operand times x^delta
- lead_hi  out  CW  coefficient deg_hi of poly_hi
- lead_lo  out  CW  coefficient deg_hi of poly_lo_sh
- delta  out  DW  deg_hi - deg_lo
- swapped  out  1  1 when B was the higher operand
- zero_lo  out  1  lower operand is the all-zero polynomial
- deg_err  out  1  supplied degree inconsistent (optional feature)
- busy  out  1  high from start acceptance until align_done
- align_done  out  1  one-cycle pulse; outputs valid from this cycle until next accepted start

Behaviour:
- Reset (rst_b=1 at a clock edge, any state):
  - State goes to IDLE.
  - All outputs and internal registers are cleared to 0.
  - No align_done pulse; an in-flight operation is discarded.
- FSM states:
  - IDLE: on start=1, latch poly_a/deg_a/poly_b/deg_b, set busy=1, go to CMP. Otherwise stay in IDLE and hold outputs.
  - CMP: swap = (deg_b > deg_a), so ties do not swap. Load poly_hi, the lo shift register, delta, swapped, lead_hi. zero_lo = (lo operand == 0). Load the shift counter with delta, forced to 0 when zero_lo=1. Go to SHIFT if the counter is nonzero, else to DONE.
  - SHIFT: each cycle, lo register <= {CW zeros, lo[0:M-CW-1]} (multiply by x) and the counter decrements. Go to DONE when the counter reaches 1.
  - DONE: lead_lo = coefficient deg_hi of the lo register. align_done=1 and busy=0 for exactly this cycle. Go to IDLE.
- Latency: align_done is high 2+delta cycles after the start-accepting edge (minimum 2, maximum 10).
- start while busy is ignored; there is no queueing.
- Inputs are sampled only at start acceptance and may change afterwards.
- Coefficient 8 shifted out is discarded. With consistent degrees it is always zero.
- delta reports 0 when zero_lo=1. lead_lo is then 0.
- Outputs hold after DONE until the next accepted start updates them in CMP.

Optional Feature:
- Macro POLY_EUCLID_ALIGN_DEG_CHECK_EN.
- Defined: in CMP, check for each operand that coefficient deg is nonzero (unless the polynomial is zero) and that all coefficients above deg are zero. deg_err is registered and held with the other results; it is valid at align_done. Shifting proceeds regardless.
- Undefined: the checker is absent and deg_err is tied 0.

Decomposition:
- Shared package holds:
  - M, CW, NC, DW
  - state encoding IDLE/CMP/SHIFT/DONE
  - coefficient slice offset function (index*CW)
- One sub-module, poly_coef_sel: combinational NC-to-1 coefficient mux by DW index. It is instantiated twice, for lead_hi and lead_lo.

Test Plan:
- A = x^5 (coef5=0x0001), deg_a=5; B = 3x^2+7 (coef2=0x0003, coef0=0x0007), deg_b=2.
  -> swapped=0, delta=3, lead_hi=0x0001, lead_lo=0x0003.
  -> poly_lo_sh has coef5=0x0003 and coef3=0x0007.
  -> align_done exactly 5 cycles after start.
- Same operands with A and B exchanged.
  -> swapped=1, identical poly_hi, poly_lo_sh and lead values.
- deg_a = deg_b = 4, coef4 = 0x1234 and 0xABCD.
  -> swapped=0, delta=0, no SHIFT cycles, align_done 2 cycles after start.
- A: deg 8 with coef8=0xFFFF; B = 0 (deg 0).
  -> zero_lo=1, delta=0, lead_lo=0, align_done after 2 cycles.
- A: deg 8; B: deg 0 with coef0=0x0002.
  -> delta=8, poly_lo_sh coef8=0x0002, all other coefficients 0, align_done after 10 cycles.
  -> start pulses during busy are ignored.
  -> rst_b asserted in the 3rd SHIFT cycle: next cycle IDLE, all outputs 0, no align_done.
- With POLY_EUCLID_ALIGN_DEG_CHECK_EN: A coef6 nonzero but deg_a=5.
  -> deg_err=1 at align_done.
  -> Without the macro, deg_err stays 0.

Source files
------------

// File: rtl/poly_euclid_align_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : poly_euclid_align_pkg
//  Purpose  : Shared sizes, state encoding and coefficient slice helper for
//             the GF(2^16) polynomial degree-alignment block.
//  Revision : 1.0 - initial release
// ============================================================================
package poly_euclid_align_pkg;

    localparam int M  = 144;
    localparam int CW = 16;
    localparam int NC = M / CW;
    localparam int DW = 4;
    localparam int SW = 2;

    localparam logic [SW-1:0] S_IDLE  = 2'd0;
    localparam logic [SW-1:0] S_CMP   = 2'd1;
    localparam logic [SW-1:0] S_SHIFT = 2'd2;
    localparam logic [SW-1:0] S_DONE  = 2'd3;

    function automatic int coef_off(input int idx);
        return idx * CW;
    endfunction

endpackage
`default_nettype wire

// File: rtl/poly_euclid_align_coef_sel.sv
`default_nettype none
// ============================================================================
//  Module   : poly_coef_sel
//  Purpose  : Combinational NC-to-1 coefficient mux; out-of-range index
//             returns zero.
//  Revision : 1.0 - initial release
// ============================================================================
module poly_coef_sel
    import poly_euclid_align_pkg::*;
(
    input  logic [0:M-1]  i_poly,
    input  logic [DW-1:0] i_idx,
    output logic [CW-1:0] o_coef
);

    always_comb begin
        o_coef = '0;
        for (int i = 0; i < NC; i++) begin
            if (i_idx == DW'(i)) o_coef = i_poly[coef_off(i) +: CW];
        end
    end

endmodule
`default_nettype wire

// File: rtl/poly_euclid_align.sv
`default_nettype none
// ============================================================================
//  Module   : poly_euclid_align
//  Purpose  : Orders two GF(2^16) polynomials by degree and shifts the lower
//             one by x^delta, one coefficient per cycle, so leading terms line
//             up. Optional degree checker: POLY_EUCLID_ALIGN_DEG_CHECK_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module poly_euclid_align
    import poly_euclid_align_pkg::*;
(
    input  logic          clk,
    input  logic          rst_b,
    input  logic          start,
    input  logic [0:M-1]  poly_a,
    input  logic [DW-1:0] deg_a,
    input  logic [0:M-1]  poly_b,
    input  logic [DW-1:0] deg_b,
    output logic [0:M-1]  poly_hi,
    output logic [0:M-1]  poly_lo_sh,
    output logic [CW-1:0] lead_hi,
    output logic [CW-1:0] lead_lo,
    output logic [DW-1:0] delta,
    output logic          swapped,
    output logic          zero_lo,
    output logic          deg_err,
    output logic          busy,
    output logic          align_done
);

    logic [SW-1:0] r_state;
    logic [SW-1:0] w_state_nxt;

    logic [0:M-1]  r_a, r_b, r_hi, r_lo;
    logic [DW-1:0] r_deg_a, r_deg_b, r_deg_hi, r_delta, r_cnt;
    logic [CW-1:0] r_lead_hi, r_lead_lo;
    logic          r_swapped, r_zero_lo, r_deg_err, r_busy, r_done;

    logic          w_swap, w_zero_lo, w_deg_err;
    logic [0:M-1]  w_hi, w_lo;
    logic [DW-1:0] w_deg_hi, w_deg_lo, w_delta;
    logic [CW-1:0] w_lead_hi, w_lead_lo;

    // Ties keep A as the higher operand.
    assign w_swap    = (r_deg_b > r_deg_a);
    assign w_hi      = w_swap ? r_b : r_a;
    assign w_lo      = w_swap ? r_a : r_b;
    assign w_deg_hi  = w_swap ? r_deg_b : r_deg_a;
    assign w_deg_lo  = w_swap ? r_deg_a : r_deg_b;
    assign w_zero_lo = (w_lo == '0);
    assign w_delta   = w_zero_lo ? '0 : (w_deg_hi - w_deg_lo);

    poly_coef_sel u_sel_hi (
        .i_poly (w_hi),
        .i_idx  (w_deg_hi),
        .o_coef (w_lead_hi)
    );

    poly_coef_sel u_sel_lo (
        .i_poly (r_lo),
        .i_idx  (r_deg_hi),
        .o_coef (w_lead_lo)
    );

`ifdef POLY_EUCLID_ALIGN_DEG_CHECK_EN
    // A nonzero operand must have a nonzero coefficient at deg and nothing above it.
    function automatic logic deg_bad(input logic [0:M-1] p, input logic [DW-1:0] d);
        logic          bad;
        logic          nz;
        logic [CW-1:0] c;
        nz  = (p != '0);
        bad = nz && (d >= DW'(NC));
        for (int i = 0; i < NC; i++) begin
            c = p[coef_off(i) +: CW];
            if ((DW'(i) == d) && nz && (c == '0)) bad = 1'b1;
            if ((DW'(i) > d) && (c != '0))        bad = 1'b1;
        end
        return bad;
    endfunction

    assign w_deg_err = deg_bad(r_a, r_deg_a) | deg_bad(r_b, r_deg_b);
`else
    assign w_deg_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst_b) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_nxt = S_CMP;
            S_CMP:   w_state_nxt = (w_delta != '0) ? S_SHIFT : S_DONE;
            S_SHIFT: if (r_cnt == DW'(1)) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_b) begin
            r_a       <= '0;
            r_b       <= '0;
            r_deg_a   <= '0;
            r_deg_b   <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_deg_hi  <= '0;
            r_delta   <= '0;
            r_cnt     <= '0;
            r_lead_hi <= '0;
            r_lead_lo <= '0;
            r_swapped <= 1'b0;
            r_zero_lo <= 1'b0;
            r_deg_err <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_a     <= poly_a;
                        r_b     <= poly_b;
                        r_deg_a <= deg_a;
                        r_deg_b <= deg_b;
                        r_busy  <= 1'b1;
                    end
                end
                S_CMP: begin
                    r_hi      <= w_hi;
                    r_lo      <= w_lo;
                    r_deg_hi  <= w_deg_hi;
                    r_delta   <= w_delta;
                    r_cnt     <= w_delta;
                    r_swapped <= w_swap;
                    r_zero_lo <= w_zero_lo;
                    r_lead_hi <= w_lead_hi;
                    r_deg_err <= w_deg_err;
                end
                S_SHIFT: begin
                    // Multiply by x: coefficient i moves to i+1, top one falls off.
                    r_lo  <= {{CW{1'b0}}, r_lo[0:M-CW-1]};
                    r_cnt <= r_cnt - DW'(1);
                end
                S_DONE: begin
                    r_lead_lo <= w_lead_lo;
                    r_done    <= 1'b1;
                    r_busy    <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign poly_hi    = r_hi;
    assign poly_lo_sh = r_lo;
    assign lead_hi    = r_lead_hi;
    assign lead_lo    = r_lead_lo;
    assign delta      = r_delta;
    assign swapped    = r_swapped;
    assign zero_lo    = r_zero_lo;
    assign deg_err    = r_deg_err;
    assign busy       = r_busy;
    assign align_done = r_done;

endmodule
`default_nettype wire

// File: tb/tb_poly_euclid_align.sv
`default_nettype none
// ============================================================================
//  Module   : tb_poly_euclid_align
//  Purpose  : Scoreboard bench for poly_euclid_align against a coefficient-
//             array reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_poly_euclid_align;

    localparam int M  = 144;
    localparam int CW = 16;
    localparam int NC = 9;
    localparam int DW = 4;

    typedef struct {
        logic [0:M-1]  hi;
        logic [0:M-1]  lo;
        logic [CW-1:0] lh;
        logic [CW-1:0] ll;
        int            dlt;
        logic          sw;
        logic          zl;
        logic          de;
        int            c0;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_b = 1'b1;
    logic          start = 1'b0;
    logic [0:M-1]  poly_a = '0;
    logic [0:M-1]  poly_b = '0;
    logic [DW-1:0] deg_a = '0;
    logic [DW-1:0] deg_b = '0;
    logic [0:M-1]  poly_hi, poly_lo_sh;
    logic [CW-1:0] lead_hi, lead_lo;
    logic [DW-1:0] delta;
    logic          swapped, zero_lo, deg_err, busy, align_done;

    poly_euclid_align dut (
        .clk        (clk),
        .rst_b      (rst_b),
        .start      (start),
        .poly_a     (poly_a),
        .deg_a      (deg_a),
        .poly_b     (poly_b),
        .deg_b      (deg_b),
        .poly_hi    (poly_hi),
        .poly_lo_sh (poly_lo_sh),
        .lead_hi    (lead_hi),
        .lead_lo    (lead_lo),
        .delta      (delta),
        .swapped    (swapped),
        .zero_lo    (zero_lo),
        .deg_err    (deg_err),
        .busy       (busy),
        .align_done (align_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_fail = 0;
    exp_t q[$];
    logic [CW-1:0] ca [NC];
    logic [CW-1:0] cb [NC];

    task automatic chk(input string name, input logic [M-1:0] act, input logic [M-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [0:M-1] pack(input logic [CW-1:0] c [NC]);
        logic [0:M-1] p;
        for (int i = 0; i < NC; i++) p[i*CW +: CW] = c[i];
        return p;
    endfunction

    // Highest nonzero coefficient index, -1 for the zero polynomial.
    function automatic int true_deg(input logic [CW-1:0] c [NC]);
        int d;
        d = -1;
        for (int i = 0; i < NC; i++) if (c[i] != 0) d = i;
        return d;
    endfunction

    function automatic exp_t model(input int da, input int db);
        exp_t e;
        logic [CW-1:0] hi [NC];
        logic [CW-1:0] lo [NC];
        logic [CW-1:0] sh [NC];
        int dh, dl;
        e.sw = (db > da);
        if (e.sw) begin hi = cb; lo = ca; dh = db; dl = da; end
        else      begin hi = ca; lo = cb; dh = da; dl = db; end
        e.zl  = (true_deg(lo) < 0);
        e.dlt = e.zl ? 0 : dh - dl;
        for (int i = 0; i < NC; i++) sh[i] = (i >= e.dlt) ? lo[i - e.dlt] : '0;
        e.hi = pack(hi);
        e.lo = pack(sh);
        e.lh = (dh < NC) ? hi[dh] : '0;
        e.ll = (dh < NC) ? sh[dh] : '0;
`ifdef POLY_EUCLID_ALIGN_DEG_CHECK_EN
        e.de = ((true_deg(ca) >= 0) && (true_deg(ca) != da)) ||
               ((true_deg(cb) >= 0) && (true_deg(cb) != db));
`else
        e.de = 1'b0;
`endif
        e.c0 = 0;
        return e;
    endfunction

    task automatic scramble();
        for (int i = 0; i < NC; i++) begin
            poly_a[i*CW +: CW] = CW'($urandom);
            poly_b[i*CW +: CW] = CW'($urandom);
        end
        deg_a = DW'($urandom);
        deg_b = DW'($urandom);
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (busy !== 1'b0 && k < 40) begin
            @(negedge clk);
            k++;
        end
        if (k >= 40) begin
            n_chk++;
            n_fail++;
            $display("FAIL busy_timeout: busy still %b after %0d cycles", busy, k);
        end
        @(negedge clk);
    endtask

    // Issue one operation from ca/cb; optional noise drives start pulses while busy.
    task automatic issue(input int da, input int db, input bit noise);
        exp_t e;
        e = model(da, db);
        @(negedge clk);
        poly_a = pack(ca);
        poly_b = pack(cb);
        deg_a  = DW'(da);
        deg_b  = DW'(db);
        start  = 1'b1;
        e.c0   = cyc;
        q.push_back(e);
        @(negedge clk);
        start = 1'b0;
        scramble();
        if (noise) begin
            repeat (3) begin
                @(negedge clk);
                start = 1'b1;
                scramble();
            end
            @(negedge clk);
            start = 1'b0;
        end
        wait_idle();
    endtask

    task automatic clr();
        for (int i = 0; i < NC; i++) begin ca[i] = '0; cb[i] = '0; end
    endtask

    task automatic gen_poly(output logic [CW-1:0] c [NC], output int d);
        int mode;
        mode = $urandom_range(0, 9);
        for (int i = 0; i < NC; i++) c[i] = '0;
        if (mode == 0) begin
            d = 0;
        end else if (mode == 1) begin
            for (int i = 0; i < NC; i++) c[i] = CW'($urandom);
            d = $urandom_range(0, 8);
        end else begin
            d = $urandom_range(0, 8);
            for (int i = 0; i < d; i++) c[i] = CW'($urandom);
            c[d] = CW'($urandom_range(1, 65535));
        end
    endtask

    task automatic check_all_zero();
        chk("rst_poly_hi", poly_hi, '0);
        chk("rst_poly_lo_sh", poly_lo_sh, '0);
        chk("rst_lead_hi", M'(lead_hi), '0);
        chk("rst_lead_lo", M'(lead_lo), '0);
        chk("rst_delta", M'(delta), '0);
        chk("rst_flags", M'({swapped, zero_lo, deg_err, busy, align_done}), '0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (align_done === 1'b1) begin
            if (q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_done: align_done=1 with no operation pending");
            end else begin
                e = q.pop_front();
                chk("poly_hi", poly_hi, e.hi);
                chk("poly_lo_sh", poly_lo_sh, e.lo);
                chk("lead_hi", M'(lead_hi), M'(e.lh));
                chk("lead_lo", M'(lead_lo), M'(e.ll));
                chk("delta", M'(delta), M'(e.dlt));
                chk("swapped", M'(swapped), M'(e.sw));
                chk("zero_lo", M'(zero_lo), M'(e.zl));
                chk("deg_err", M'(deg_err), M'(e.de));
                chk("busy_at_done", M'(busy), '0);
                chk("latency", M'(cyc - e.c0 - 1), M'(2 + e.dlt));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int da, db;
        clr();
        repeat (3) @(negedge clk);
        check_all_zero();
        rst_b = 1'b0;
        @(negedge clk);

        clr(); ca[5] = 16'h0001; cb[2] = 16'h0003; cb[0] = 16'h0007;
        issue(5, 2, 1'b0);
        clr(); cb[5] = 16'h0001; ca[2] = 16'h0003; ca[0] = 16'h0007;
        issue(2, 5, 1'b0);
        clr(); ca[4] = 16'h1234; cb[4] = 16'hABCD;
        issue(4, 4, 1'b0);
        clr(); ca[8] = 16'hFFFF;
        issue(8, 0, 1'b0);
        clr(); ca[8] = 16'h5A5A; ca[1] = 16'h0100; cb[0] = 16'h0002;
        issue(8, 0, 1'b1);
        clr(); ca[6] = 16'h0009; ca[5] = 16'h0001; cb[3] = 16'h0042;
        issue(5, 3, 1'b0);

        // Reset during the third SHIFT cycle of a delta-8 operation.
        clr(); ca[8] = 16'h0001; cb[0] = 16'h0002;
        @(negedge clk);
        poly_a = pack(ca); poly_b = pack(cb); deg_a = 4'd8; deg_b = 4'd0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst_b = 1'b1;
        @(negedge clk);
        rst_b = 1'b0;
        check_all_zero();
        repeat (14) @(negedge clk);

        for (int t = 0; t < 40; t++) begin
            gen_poly(ca, da);
            gen_poly(cb, db);
            issue(da, db, 1'b0);
        end

        repeat (5) @(negedge clk);
        chk("queue_empty", M'(q.size()), '0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
